// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//   Synchronous N-digit BCD counter. Every digit updates on the same CK edge,
//   so the outputs show no ripple skew. Supports count enable, synchronous
//   clear, validated parallel load, wrap or saturate at the terminal value,
//   and a one-cycle carry pulse. All outputs are registered.
//
// Parameters
//   DIGITS  number of BCD digits (>= 1); Q is 4*DIGITS bits wide
//   WRAP    1: all nines -> 0 rolls over; 0: saturate at all nines
//
// Ports
//   CK        in   clock, rising edge
//   nClear    in   asynchronous active-low reset
//   en        in   count enable
//   clr       in   synchronous clear (highest priority)
//   load      in   synchronous parallel load of D (rejected if any nibble > 9)
//   D         in   load value, digit 0 = D[3:0]
//   dn        in   count direction, 1 = down (only with BCD_CNT_UPDOWN_EN)
//   Q         out  count value, digit 0 = Q[3:0]
//   carry     out  one-cycle pulse on a terminal step (wrap or attempt past limit)
//   load_err  out  one-cycle pulse when a load is rejected
//
// Configuration
//   `define BCD_CNT_UPDOWN_EN adds port dn and down counting with borrow.
//   Without it the counter counts up only.
// -----------------------------------------------------------------------------
module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  CK,
  input  logic                  nClear,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   D,
`ifdef BCD_CNT_UPDOWN_EN
  input  logic                  dn,
`endif
  output logic [4*DIGITS-1:0]   Q,
  output logic                  carry,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         carry_q, carry_d;
  logic         load_err_q, load_err_d;

  logic         down;
  logic         d_valid;
  logic [W-1:0] step_val;
  logic         chain;
  logic [3:0]   digit;

`ifdef BCD_CNT_UPDOWN_EN
  assign down = dn;
`else
  assign down = 1'b0;
`endif

  // A load is accepted only if every nibble is a legal BCD digit.
  always_comb begin
    d_valid = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (D[4*k +: 4] > 4'd9) d_valid = 1'b0;
    end
  end

  // One-step count value. `chain` is true while every lower digit sits at its
  // terminal value (9 going up, 0 going down), so the digit it reaches steps.
  // After the loop it is true only if all digits are terminal, i.e. the
  // counter is at its limit; the wrapped step value then falls out naturally
  // (all nines -> zeros, zeros -> all nines).
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    step_val = q_q;
    chain    = 1'b1;
    digit    = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = q_q[4*k +: 4];
      if (chain) begin
        if (down) step_val[4*k +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        else      step_val[4*k +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      end
      chain = chain & (down ? (digit == 4'd0) : (digit == 4'd9));
    end
  end

  // Priority: clr > load > en. Pulses default low so they never linger.
  always_comb begin
    q_d        = q_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      if (d_valid) q_d        = D;
      else         load_err_d = 1'b1;
    end else if (en) begin
      carry_d = chain;
      // Saturating mode holds at the limit but still flags the attempt.
      if (!(chain && !WRAP)) q_d = step_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CK or negedge nClear) begin
    if (!nClear) begin
      q_q        <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
//   Drives three counter instances from shared controls:
//     inst 0: DIGITS=2 WRAP=1, inst 1: DIGITS=2 WRAP=0, inst 2: DIGITS=3 WRAP=1.
//   A reference model keeps each count as a plain integer; expected outputs are
//   queued at stimulus time and a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

`ifdef BCD_CNT_UPDOWN_EN
  localparam bit UPDOWN = 1'b1;
`else
  localparam bit UPDOWN = 1'b0;
`endif

  logic        CK;
  logic        nClear;
  logic        en, clr, load, dn;
  logic [11:0] d_bus;

  logic [7:0]  q0, q1;
  logic [11:0] q2;
  logic        c0, c1, c2;
  logic        e0, e1, e2;

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_wrap2 (
    .CK(CK), .nClear(nClear), .en(en), .clr(clr), .load(load), .D(d_bus[7:0]),
`ifdef BCD_CNT_UPDOWN_EN
    .dn(dn),
`endif
    .Q(q0), .carry(c0), .load_err(e0));

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_sat2 (
    .CK(CK), .nClear(nClear), .en(en), .clr(clr), .load(load), .D(d_bus[7:0]),
`ifdef BCD_CNT_UPDOWN_EN
    .dn(dn),
`endif
    .Q(q1), .carry(c1), .load_err(e1));

  bcd_counter_n #(.DIGITS(3), .WRAP(1'b1)) u_wrap3 (
    .CK(CK), .nClear(nClear), .en(en), .clr(clr), .load(load), .D(d_bus),
`ifdef BCD_CNT_UPDOWN_EN
    .dn(dn),
`endif
    .Q(q2), .carry(c2), .load_err(e2));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  typedef struct packed {
    logic [2:0][11:0] q;
    logic [2:0]       c;
    logic [2:0]       e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: counts as integers.
  int val[3];
  bit mc[3], me[3];

  function automatic int digits_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic bit wrap_of(int i);
    return (i != 1);
  endfunction

  function automatic logic [11:0] to_bcd(int v);
    logic [11:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic void model_step(int i, bit e, bit c, bit l, logic [11:0] d, bit down);
    int nd, maxv, dv, p;
    bit ok;
    logic [3:0] nib;
    nd   = digits_of(i);
    maxv = (nd == 2) ? 99 : 999;
    ok   = 1'b1;
    dv   = 0;
    p    = 1;
    for (int k = 0; k < nd; k++) begin
      nib = d[4*k +: 4];
      if (nib > 4'd9) ok = 1'b0;
      dv += int'(nib) * p;
      p  *= 10;
    end
    mc[i] = 1'b0;
    me[i] = 1'b0;
    if (c) val[i] = 0;
    else if (l) begin
      if (ok) val[i] = dv;
      else    me[i]  = 1'b1;
    end else if (e) begin
      if (!down) begin
        if (val[i] == maxv) begin mc[i] = 1'b1; if (wrap_of(i)) val[i] = 0; end
        else val[i] = val[i] + 1;
      end else begin
        if (val[i] == 0) begin mc[i] = 1'b1; if (wrap_of(i)) val[i] = maxv; end
        else val[i] = val[i] - 1;
      end
    end
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue the expected post-edge outputs.
  task automatic drive(bit e, bit c, bit l, logic [11:0] d, bit down);
    exp_t x;
    @(negedge CK);
    en = e; clr = c; load = l; d_bus = d; dn = down;
    for (int i = 0; i < 3; i++) begin
      model_step(i, e, c, l, d, UPDOWN && down);
      x.q[i] = to_bcd(val[i]);
      x.c[i] = mc[i];
      x.e[i] = me[i];
    end
    sb.push_back(x);
  endtask

  // Monitor: outputs are presented every edge; compare against the queue head.
  always @(posedge CK) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("q_wrap2",  {4'h0, q0}, x.q[0]);
      check("q_sat2",   {4'h0, q1}, x.q[1]);
      check("q_wrap3",  q2,         x.q[2]);
      check("carry",    {9'h0, c2, c1, c0}, {9'h0, x.c});
      check("load_err", {9'h0, e2, e1, e0}, {9'h0, x.e});
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_q"}, {4'h0, q0} | {4'h0, q1} | q2, 12'h000);
    check({tag, "_pulses"}, {6'h0, c2, c1, c0, e2, e1, e0}, 12'h000);
  endtask

  function automatic logic [11:0] rand_d();
    logic [11:0] d;
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) begin
      case ($urandom_range(0, 5))
        0: d = 12'h099;
        1: d = 12'h998;
        2: d = 12'h999;
        3: d = 12'h000;
        4: d = 12'h001;
        default: d = 12'h100;
      endcase
    end else begin
      d = '0;
      for (int k = 0; k < 3; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) d[4*$urandom_range(0, 1) +: 4] = 4'($urandom_range(10, 15));
    end
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin val[i] = 0; mc[i] = 0; me[i] = 0; end
    // Reset held across edges while enabled: counts must stay at zero.
    nClear = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0; d_bus = '0; dn = 1'b0;
    repeat (2) begin
      @(posedge CK); #1;
      check_zero("reset_hold");
    end
    @(negedge CK);
    nClear = 1'b1;
    en = 1'b0;

    // Count 100 edges from zero (wrap, saturate, and 3-digit carry into hundreds).
    repeat (100) drive(1, 0, 0, 12'h000, 0);
    drive(0, 0, 0, 12'h000, 0);

    // Saturate region: load 98, three enabled edges, then idle.
    drive(0, 0, 1, 12'h098, 0);
    repeat (3) drive(1, 0, 0, 12'h000, 0);
    drive(0, 0, 0, 12'h000, 0);

    // Load validation, then an asynchronous reset pulse between edges.
    drive(0, 0, 1, 12'h047, 0);
    drive(0, 0, 1, 12'h04A, 0);
    @(posedge CK); #3;
    nClear = 1'b0;
    #1;
    check_zero("reset_pulse");
    nClear = 1'b1;
    for (int i = 0; i < 3; i++) val[i] = 0;

    drive(0, 0, 1, 12'h047, 0);
    drive(0, 1, 1, 12'h04A, 0);
    // Priority: clr over load over en; load over en.
    drive(0, 0, 1, 12'h055, 0);
    drive(1, 1, 1, 12'h012, 0);
    drive(1, 0, 1, 12'h012, 0);
    drive(1, 0, 0, 12'h000, 0);

    if (UPDOWN) begin
      drive(0, 0, 1, 12'h010, 0);
      repeat (2) drive(1, 0, 0, 12'h000, 1);
      drive(0, 0, 1, 12'h100, 0);
      repeat (2) drive(1, 0, 0, 12'h000, 1);
      drive(0, 1, 0, 12'h000, 0);
      drive(1, 0, 0, 12'h000, 1);
      drive(1, 0, 1, 12'h000, 1);
    end

    // Randomized traffic.
    repeat (400) begin
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0,
            rand_d(),
            UPDOWN ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    drive(0, 0, 0, 12'h000, 0);

    repeat (3) @(posedge CK);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
